// File: rtl/fmul_unpack_seq.sv
// ============================================================================
// Module      : fmul_unpack_seq
// Description : binary32 multiplier front end. Unpacks and classifies both
//               operands, forms the biased sum exponent and an iterative
//               radix-2 shift-add 24x24 significand product for the pack stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fmul_unpack_seq #(
    parameter int          FAST_SPECIAL = 1,
    parameter logic [22:0] QNAN_FRAC    = 23'h400000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  rm_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  rm,
    output logic        sign,
    output logic [9:0]  exp10,
    output logic        is_nan,
    output logic        is_inf,
    output logic [22:0] inf_nan_frac,
    output logic [47:0] z
);

    localparam logic [9:0] c_bias      = 10'd127;
    localparam logic [4:0] c_last_step = 5'd23;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [23:0] r_mant_a;
    logic [48:0] r_p;
    logic [4:0]  r_step;

    // Operand unpack: a zero exponent means denormal/zero, which uses an
    // effective exponent of 1 and no hidden bit.
    logic [7:0]  w_exp_a, w_exp_b;
    logic [22:0] w_frac_a, w_frac_b;
    logic [7:0]  w_eff_a, w_eff_b;
    logic [23:0] w_mant_a, w_mant_b;

    assign w_exp_a  = a[30:23];
    assign w_exp_b  = b[30:23];
    assign w_frac_a = a[22:0];
    assign w_frac_b = b[22:0];
    assign w_eff_a  = (w_exp_a == 8'd0) ? 8'd1 : w_exp_a;
    assign w_eff_b  = (w_exp_b == 8'd0) ? 8'd1 : w_exp_b;
    assign w_mant_a = {(w_exp_a != 8'd0), w_frac_a};
    assign w_mant_b = {(w_exp_b != 8'd0), w_frac_b};

    logic w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_zero_a, w_zero_b;
    logic w_is_nan, w_is_inf, w_special, w_fast;
    logic [9:0] w_exp10;

    assign w_nan_a  = (w_exp_a == 8'hFF) && (w_frac_a != 23'd0);
    assign w_nan_b  = (w_exp_b == 8'hFF) && (w_frac_b != 23'd0);
    assign w_inf_a  = (w_exp_a == 8'hFF) && (w_frac_a == 23'd0);
    assign w_inf_b  = (w_exp_b == 8'hFF) && (w_frac_b == 23'd0);
    assign w_zero_a = (w_exp_a == 8'd0)  && (w_frac_a == 23'd0);
    assign w_zero_b = (w_exp_b == 8'd0)  && (w_frac_b == 23'd0);

    assign w_is_nan  = w_nan_a | w_nan_b | (w_inf_a & w_zero_b) | (w_zero_a & w_inf_b);
    assign w_is_inf  = (w_inf_a | w_inf_b) & ~w_is_nan;
    assign w_special = w_is_nan | w_is_inf | w_zero_a | w_zero_b;
    assign w_fast    = (FAST_SPECIAL != 0) && w_special;
    assign w_exp10   = {2'b00, w_eff_a} + {2'b00, w_eff_b} - c_bias;

    // One shift-add step: conditionally add multiplicand into the upper half,
    // then shift the whole 49-bit accumulator right by one.
    logic [24:0] w_sum;
    logic [47:0] w_p_next;

    assign w_sum    = r_p[48:24] + (r_p[0] ? {1'b0, r_mant_a} : 25'd0);
    assign w_p_next = {w_sum, r_p[23:1]};

    assign in_ready = (r_state == S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_mant_a     <= 24'd0;
            r_p          <= 49'd0;
            r_step       <= 5'd0;
            out_valid    <= 1'b0;
            rm           <= 2'd0;
            sign         <= 1'b0;
            exp10        <= 10'd0;
            is_nan       <= 1'b0;
            is_inf       <= 1'b0;
            inf_nan_frac <= 23'd0;
            z            <= 48'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        rm           <= rm_in;
                        sign         <= a[31] ^ b[31];
                        exp10        <= w_exp10;
                        is_nan       <= w_is_nan;
                        is_inf       <= w_is_inf;
                        inf_nan_frac <= w_is_nan ? QNAN_FRAC : 23'd0;
                        r_mant_a     <= w_mant_a;
                        r_p          <= {25'd0, w_mant_b};
                        r_step       <= 5'd0;
                        if (w_fast) begin
                            z       <= 48'd0;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    r_p <= {1'b0, w_p_next};
                    if (r_step == c_last_step) begin
                        z       <= w_p_next;
                        r_step  <= 5'd0;
                        r_state <= S_DONE;
                    end else begin
                        r_step <= r_step + 5'd1;
                    end
                end
                S_DONE: begin
                    // out_valid rises one edge after entering DONE.
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fmul_unpack_seq.sv
// ============================================================================
// Module      : tb_fmul_unpack_seq
// Description : directed self-checking bench for fmul_unpack_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fmul_unpack_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  rm_in;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  rm;
    logic        sign;
    logic [9:0]  exp10;
    logic        is_nan;
    logic        is_inf;
    logic [22:0] inf_nan_frac;
    logic [47:0] z;

    int n_checks = 0;
    int n_errors = 0;
    int lat;

    fmul_unpack_seq #(
        .FAST_SPECIAL (1),
        .QNAN_FRAC    (23'h400000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .a            (a),
        .b            (b),
        .rm_in        (rm_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .rm           (rm),
        .sign         (sign),
        .exp10        (exp10),
        .is_nan       (is_nan),
        .is_inf       (is_inf),
        .inf_nan_frac (inf_nan_frac),
        .z            (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Accept one operand pair, then wait for out_valid; lat counts edges after accept.
    task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic [1:0] trm);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        a        = ta;
        b        = tb;
        rm_in    = trm;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("release_ov", {63'd0, out_valid}, 64'd0);
        check("release_rdy", {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = 32'd0;
        b         = 32'd0;
        rm_in     = 2'd0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_ov", {63'd0, out_valid}, 64'd0);
        check("rst_rdy", {63'd0, in_ready}, 64'd1);
        check("rst_z", {16'd0, z}, 64'd0);
        check("rst_exp", {54'd0, exp10}, 64'd0);

        // 1.0 * 2.0
        send(32'h3F800000, 32'h40000000, 2'd0);
        check("t1_lat", lat, 64'd25);
        check("t1_sign", {63'd0, sign}, 64'd0);
        check("t1_exp", {54'd0, exp10}, 64'h080);
        check("t1_z", {16'd0, z}, 64'h4000_0000_0000);
        check("t1_nan", {63'd0, is_nan}, 64'd0);
        check("t1_inf", {63'd0, is_inf}, 64'd0);
        release_result();

        // 1.5 * -1.5 with backpressure; a busy in_valid must be ignored
        send(32'h3FC00000, 32'hBFC00000, 2'd1);
        check("t2_lat", lat, 64'd25);
        a        = 32'h7FC00000;
        b        = 32'h00000000;
        rm_in    = 2'd3;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("t2_hold_ov", {63'd0, out_valid}, 64'd1);
            check("t2_hold_rdy", {63'd0, in_ready}, 64'd0);
            check("t2_hold_fields", {11'd0, rm, sign, exp10, is_nan, is_inf},
                  {11'd0, 2'd1, 1'b1, 10'h07F, 1'b0, 1'b0});
            check("t2_hold_z", {16'd0, z}, 64'h9000_0000_0000);
        end
        in_valid = 1'b0;
        release_result();

        // NaN operand, fast path
        send(32'h7FC00000, 32'h3F800000, 2'd0);
        check("t3_lat", lat, 64'd1);
        check("t3_nan", {63'd0, is_nan}, 64'd1);
        check("t3_inf", {63'd0, is_inf}, 64'd0);
        check("t3_frac", {41'd0, inf_nan_frac}, 64'h400000);
        check("t3_z", {16'd0, z}, 64'd0);
        check("t3_exp", {54'd0, exp10}, 64'h0FF);
        release_result();

        // Inf * 0 is NaN
        send(32'h7F800000, 32'h00000000, 2'd0);
        check("t4_lat", lat, 64'd1);
        check("t4_nan", {63'd0, is_nan}, 64'd1);
        check("t4_inf", {63'd0, is_inf}, 64'd0);
        check("t4_exp", {54'd0, exp10}, 64'h081);
        release_result();

        // Inf * -2.0
        send(32'h7F800000, 32'hC0000000, 2'd2);
        check("t5_lat", lat, 64'd1);
        check("t5_inf", {63'd0, is_inf}, 64'd1);
        check("t5_nan", {63'd0, is_nan}, 64'd0);
        check("t5_sign", {63'd0, sign}, 64'd1);
        check("t5_frac", {41'd0, inf_nan_frac}, 64'd0);
        check("t5_rm", {62'd0, rm}, 64'd2);
        release_result();

        // Smallest denormal * 1.0
        send(32'h00000001, 32'h3F800000, 2'd0);
        check("t6_lat", lat, 64'd25);
        check("t6_exp", {54'd0, exp10}, 64'h001);
        check("t6_z", {16'd0, z}, 64'h0000_0080_0000);
        release_result();

        // Reset at step 10 of a multiply
        @(negedge clk);
        a        = 32'h40400000;
        b        = 32'h40A00000;
        rm_in    = 2'd3;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t7_rdy", {63'd0, in_ready}, 64'd1);
        check("t7_ov", {63'd0, out_valid}, 64'd0);
        check("t7_fields", {11'd0, rm, sign, exp10, is_nan, is_inf}, 64'd0);
        check("t7_frac", {41'd0, inf_nan_frac}, 64'd0);
        check("t7_z", {16'd0, z}, 64'd0);

        // Back-to-back with out_ready tied high
        out_ready = 1'b1;
        send(32'h40400000, 32'h40A00000, 2'd2);
        check("t8a_lat", lat, 64'd25);
        check("t8a_z", {16'd0, z}, 64'h7800_0000_0000);
        check("t8a_exp", {54'd0, exp10}, 64'h082);
        check("t8a_rm", {62'd0, rm}, 64'd2);
        send(32'hBF800000, 32'h3F000000, 2'd3);
        check("t8b_lat", lat, 64'd25);
        check("t8b_z", {16'd0, z}, 64'h4000_0000_0000);
        check("t8b_exp", {54'd0, exp10}, 64'h07E);
        check("t8b_sign", {63'd0, sign}, 64'd1);
        check("t8b_rm", {62'd0, rm}, 64'd3);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("t8_end_ov", {63'd0, out_valid}, 64'd0);
        check("t8_end_rdy", {63'd0, in_ready}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
